// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch and data upstream ports plus the shared memory port.
// slave = arbiter side, master = the surrounding core/memory environment.
interface mem_arbiter_if #(parameter int ADDR_W = 32);
    logic              Inst_Req_Valid;
    logic              Inst_Req_Ack;
    logic [ADDR_W-1:0] Inst_Addr;
    logic              Inst_Valid;
    logic              Inst_Ack;
    logic [31:0]       Instruction;

    logic              Mem_Req_Valid;
    logic              Mem_Req_Ack;
    logic              Mem_Write;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [31:0]       Mem_Wdata;
    logic [3:0]        Mem_Strb;
    logic              Read_data_Valid;
    logic              Read_data_Ack;
    logic [31:0]       Read_data;

    logic              M_Req_Valid;
    logic              M_Req_Ack;
    logic              M_Write;
    logic [ADDR_W-1:0] M_Addr;
    logic [31:0]       M_Wdata;
    logic [3:0]        M_Strb;
    logic              M_Rvalid;
    logic              M_Rready;
    logic [31:0]       M_Rdata;

    modport slave (
        input  Inst_Req_Valid, Inst_Addr, Inst_Ack,
        input  Mem_Req_Valid, Mem_Write, Mem_Addr, Mem_Wdata, Mem_Strb, Read_data_Ack,
        input  M_Req_Ack, M_Rvalid, M_Rdata,
        output Inst_Req_Ack, Inst_Valid, Instruction,
        output Mem_Req_Ack, Read_data_Valid, Read_data,
        output M_Req_Valid, M_Write, M_Addr, M_Wdata, M_Strb, M_Rready
    );

    modport master (
        output Inst_Req_Valid, Inst_Addr, Inst_Ack,
        output Mem_Req_Valid, Mem_Write, Mem_Addr, Mem_Wdata, Mem_Strb, Read_data_Ack,
        output M_Req_Ack, M_Rvalid, M_Rdata,
        input  Inst_Req_Ack, Inst_Valid, Instruction,
        input  Mem_Req_Ack, Read_data_Valid, Read_data,
        input  M_Req_Valid, M_Write, M_Addr, M_Wdata, M_Strb, M_Rready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-to-one memory arbiter (fetch vs. load/store), one transaction in flight.
// Define ARB_RR_EN for round-robin tie breaking; otherwise the data side wins ties.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input logic        clk,
    input logic        rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state;
    logic              owner_data;
    logic              req_vld;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        strb_q;
    logic              grant;
    logic              grant_data;
    logic              in_resp;
    logic              rready;

`ifdef ARB_RR_EN
    logic ptr_data;  // 1: data side has priority on the next tie
    always_comb grant_data = bus.Mem_Req_Valid & (ptr_data | ~bus.Inst_Req_Valid);
`else
    always_comb grant_data = bus.Mem_Req_Valid;
`endif

    // Grants and response visibility are suppressed during reset so nothing leaks out.
    assign grant   = (state == IDLE) & ~rst & (bus.Inst_Req_Valid | bus.Mem_Req_Valid);
    assign in_resp = (state == RESP) & ~rst;
    assign rready  = in_resp & (owner_data ? bus.Read_data_Ack : bus.Inst_Ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_data <= 1'b0;
            req_vld    <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
`ifdef ARB_RR_EN
            ptr_data   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (grant) begin
                    state      <= REQ;
                    req_vld    <= 1'b1;
                    owner_data <= grant_data;
`ifdef ARB_RR_EN
                    ptr_data   <= ~grant_data;
`endif
                    if (grant_data) begin
                        wr_q    <= bus.Mem_Write;
                        addr_q  <= bus.Mem_Addr;
                        wdata_q <= bus.Mem_Wdata;
                        strb_q  <= bus.Mem_Strb;
                    end else begin
                        wr_q    <= 1'b0;
                        addr_q  <= bus.Inst_Addr;
                        wdata_q <= '0;
                        strb_q  <= 4'hF;
                    end
                end
                REQ: if (bus.M_Req_Ack) begin
                    req_vld <= 1'b0;
                    state   <= wr_q ? IDLE : RESP;  // stores have no response phase
                end
                RESP: if (bus.M_Rvalid & rready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Inst_Req_Ack    = grant & ~grant_data;
    assign bus.Mem_Req_Ack     = grant & grant_data;
    assign bus.M_Req_Valid     = req_vld;
    assign bus.M_Write         = wr_q;
    assign bus.M_Addr          = addr_q;
    assign bus.M_Wdata         = wdata_q;
    assign bus.M_Strb          = strb_q;
    assign bus.M_Rready        = rready;
    assign bus.Inst_Valid      = in_resp & ~owner_data & bus.M_Rvalid;
    assign bus.Read_data_Valid = in_resp & owner_data & bus.M_Rvalid;
    assign bus.Instruction     = (in_resp & ~owner_data) ? bus.M_Rdata : '0;
    assign bus.Read_data       = (in_resp & owner_data) ? bus.M_Rdata : '0;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports.
REQ-002 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 Inst_Req_Valid  in  1  / Inst_Req_Ack  out  1: fetch request handshake.
REQ-005 Inst_Addr  in  ADDR_W  fetch address.
REQ-006 Inst_Valid  out  1  / Inst_Ack  in  1  / Instruction  out  32: fetch response handshake and data.
REQ-007 Mem_Req_Valid  in  1  / Mem_Req_Ack  out  1 / Mem_Write  in  1: data request handshake and type (1 = store).
REQ-008 Mem_Addr  in  ADDR_W  / Mem_Wdata  in  32  / Mem_Strb  in  4: data request payload.
REQ-009 Read_data_Valid  out  1  / Read_data_Ack  in  1  / Read_data  out  32: load response handshake and data.
REQ-010 M_Req_Valid  out  1  / M_Req_Ack  in  1  / M_Write  out  1  / M_Addr  out  ADDR_W  / M_Wdata  out  32  / M_Strb  out  4: shared memory request port.
REQ-011 M_Rvalid  in  1  / M_Rready  out  1  / M_Rdata  in  32: shared memory response port.

Function
REQ-012 FSM states SHALL be IDLE, REQ, RESP; one transaction outstanding at most.
REQ-013 IDLE: if any upstream request valid, grant one (REQ-020), assert that side's Req_Ack for exactly that cycle, latch addr/write/wdata/strb and owner ID; next state REQ.
REQ-014 IDLE with no valid request: no Req_Ack, remain IDLE.
REQ-015 REQ: M_Req_Valid = 1 with latched payload held stable until M_Req_Ack = 1; instruction owner drives M_Write = 0, M_Strb = 4'hF.
REQ-016 REQ with M_Req_Ack: store -> IDLE (no response phase); fetch or load -> RESP.
REQ-017 RESP: owner's Valid = M_Rvalid, M_Rready = owner's Ack, owner's data output = M_Rdata, combinational; non-owner Valid = 0.
REQ-018 RESP: M_Rvalid & M_Rready -> IDLE next cycle; new grant earliest in that IDLE cycle (min 3 cycles per read transaction with zero-wait memory).
REQ-019 M_Rvalid outside RESP SHALL be ignored, M_Rready = 0.
REQ-020 Grant on simultaneous requests: data side wins (fixed priority) unless ARB_RR_EN is defined.
REQ-021 Requests not granted SHALL see Req_Ack = 0 and are required to hold valid; arbiter never drops a held request.
REQ-022 Upstream payload changes after Req_Ack SHALL NOT affect the transaction in flight.

Reset
REQ-023 rst SHALL force IDLE in the next cycle from any state; in-flight transaction abandoned, no response delivered.
REQ-024 Reset values: all *_Ack, *_Valid, M_Req_Valid, M_Rready, M_Write = 0; M_Addr, M_Wdata, Instruction, Read_data = 0; M_Strb = 0; round-robin pointer = instruction side.
REQ-025 rst asserted same cycle as an upstream request: no Req_Ack issued.

Configuration
REQ-026 Macro ARB_RR_EN defined: 1-bit pointer; on simultaneous requests the side not granted last wins; pointer flips on every grant.
REQ-027 ARB_RR_EN undefined: pointer logic absent, data side always wins ties.

Verification
REQ-028 Fetch only, Inst_Addr=0x00400000, zero-wait memory -> Req_Ack at cycle 0, M_Req_Valid cycle 1 addr 0x00400000, Inst_Valid cycle 2 with M_Rdata 0x24020001.
REQ-029 Store Mem_Addr=0x10, Wdata=0xDEADBEEF, Strb=4'b0011, M_Req_Ack delayed 3 cycles -> payload stable 4 cycles, returns IDLE, no Read_data_Valid.
REQ-030 Simultaneous fetch+load held 2 transactions, no ARB_RR_EN -> load granted first, fetch second; with ARB_RR_EN and pointer=instruction -> fetch first.
REQ-031 Load with Read_data_Ack low 5 cycles after M_Rvalid -> M_Rready low 5 cycles, state held RESP, completes when Ack rises.
REQ-032 rst pulsed during RESP of a fetch -> IDLE next cycle, Inst_Valid 0, later M_Rvalid ignored.
